// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register specifier width, stall-reason
// encodings and the hazard sequencer state type.
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;

  // Two-bit stall-reason codes. The hazard FSM state uses the same
  // encoding, so the registered state can be exported as-is.
  localparam logic [1:0] STALL_NONE  = 2'd0;
  localparam logic [1:0] STALL_LOAD  = 2'd1;
  localparam logic [1:0] STALL_MDU   = 2'd2;
  localparam logic [1:0] STALL_FLUSH = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN        = STALL_NONE,
    ST_LOAD_STALL = STALL_LOAD,
    ST_MDU_WAIT   = STALL_MDU,
    ST_FLUSH      = STALL_FLUSH
  } hazard_state;

endpackage

// File: rtl/mdu_busy_counter.sv
// Tracks how long a multi-cycle mult/div keeps HI/LO occupied.
// A start loads LATENCY; the count then steps down to zero and holds.
// A start while still busy restarts the count from LATENCY.
module mdu_busy_counter #(
  parameter int LATENCY = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic busy
);

  localparam int W = $clog2(LATENCY + 1);

  logic [W-1:0] cnt;

  // Load on issue, otherwise decrement toward zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= W'(LATENCY);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // Busy whenever work remains.
  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard control for the 5-stage MIPS pipeline. Detects load-use and
// MDU-occupancy hazards, squashes wrong-path fetches on taken branches,
// and drives the PC / IF-ID / ID-EX control.
//
// Pipeline control handshake: pc_write and if_id_write act as the
// "ready" of the fetch side; when either is low the upstream stage must
// hold its contents. id_ex_bubble replaces the ID/EX payload with a NOP
// in the same cycle. if_id_flush clears IF/ID at the next edge. All
// control outputs are combinational (0-cycle) from the inputs and the
// MDU busy state; stall_reason reports the state the FSM entered on the
// previous edge.
module hazard_control_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_mdu_dep,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_mdu_start,
  input  logic                  ex_branch_taken,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic                  mdu_busy,
  output logic [1:0]            stall_reason,
  output logic [CNT_W-1:0]      stall_cycles
);

  import pipeline_pkg::*;

  hazard_state state_q;
  hazard_state state_d;

  logic rs_match;
  logic rt_match;
  logic load_use;
  logic mdu_stall;
  logic cnt_busy;

  // HI/LO occupancy tracker; an issue alongside a taken branch still
  // loads because the EX op is on the correct path.
  mdu_busy_counter #(
    .LATENCY (MDU_LATENCY)
  ) u_mdu_cnt (
    .clock (clock),
    .reset (reset),
    .start (ex_mdu_start),
    .busy  (cnt_busy)
  );

  assign mdu_busy = cnt_busy;

  // Hazard detection. $0 is hard-wired zero, so a load to it never
  // creates a dependency.
  always_comb begin
    rs_match  = id_uses_rs && (id_rs == ex_rt);
    rt_match  = id_uses_rt && (id_rt == ex_rt);
    load_use  = ex_mem_read && (ex_rt != '0) && (rs_match || rt_match);
    mdu_stall = id_mdu_dep && (cnt_busy || ex_mdu_start);
  end

  // Priority control: reset-safe values, then branch flush, then
  // stall (load-use before MDU), else free-running.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    state_d      = ST_RUN;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
      state_d      = ST_RUN;
    end else if (ex_branch_taken) begin
      // ID holds a wrong-path instruction, so the flush beats any stall.
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
      state_d      = ST_FLUSH;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      state_d      = ST_LOAD_STALL;
    end else if (mdu_stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      state_d      = ST_MDU_WAIT;
    end
  end

  // FSM state register: records which action was applied last cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign stall_reason = state_q;

  // Saturating count of cycles where the PC was held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (!pc_write && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit (MDU_LATENCY=4, CNT_W=4).
module tb_hazard_control_unit;

  logic       clock;
  logic       reset;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       id_mdu_dep;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic       ex_mdu_start;
  logic       ex_branch_taken;
  logic       pc_write;
  logic       if_id_write;
  logic       id_ex_bubble;
  logic       if_id_flush;
  logic       mdu_busy;
  logic [1:0] stall_reason;
  logic [3:0] stall_cycles;

  int total;
  int bad;

  // {pc_write, if_id_write, id_ex_bubble, if_id_flush}
  logic [3:0] ctrl;
  assign ctrl = {pc_write, if_id_write, id_ex_bubble, if_id_flush};

  localparam logic [3:0] C_RUN   = 4'b1100;
  localparam logic [3:0] C_STALL = 4'b0010;
  localparam logic [3:0] C_FLUSH = 4'b1111;
  localparam logic [3:0] C_RESET = 4'b0011;

  hazard_control_unit #(
    .REG_ADDR_W  (5),
    .MDU_LATENCY (4),
    .CNT_W       (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_mdu_dep      (id_mdu_dep),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_mdu_start    (ex_mdu_start),
    .ex_branch_taken (ex_branch_taken),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_bubble    (id_ex_bubble),
    .if_id_flush     (if_id_flush),
    .mdu_busy        (mdu_busy),
    .stall_reason    (stall_reason),
    .stall_cycles    (stall_cycles)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1 unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    id_rs           = 5'd0;
    id_rt           = 5'd0;
    id_uses_rs      = 1'b0;
    id_uses_rt      = 1'b0;
    id_mdu_dep      = 1'b0;
    ex_mem_read     = 1'b0;
    ex_rt           = 5'd0;
    ex_mdu_start    = 1'b0;
    ex_branch_taken = 1'b0;
  endtask

  task automatic drive_load_use_rs(input logic [4:0] r);
    ex_mem_read = 1'b1;
    ex_rt       = r;
    id_rs       = r;
    id_uses_rs  = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive_idle();

    // Reset state
    #3;
    chk("reset_ctrl", 32'(ctrl), 32'(C_RESET));
    chk("reset_busy", 32'(mdu_busy), 32'd0);
    chk("reset_reason", 32'(stall_reason), 32'd0);
    chk("reset_cycles", 32'(stall_cycles), 32'd0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("run_ctrl", 32'(ctrl), 32'(C_RUN));

    // Load-use on rs: one stall cycle
    drive_load_use_rs(5'd5);
    #1;
    chk("lu_ctrl", 32'(ctrl), 32'(C_STALL));
    step();
    chk("lu_reason", 32'(stall_reason), 32'd1);
    chk("lu_cycles", 32'(stall_cycles), 32'd1);
    ex_mem_read = 1'b0;
    #1;
    chk("lu_release_ctrl", 32'(ctrl), 32'(C_RUN));
    step();
    chk("lu_release_reason", 32'(stall_reason), 32'd0);
    chk("lu_release_cycles", 32'(stall_cycles), 32'd1);

    // Load-use on rt, then non-hazard variants (combinational only)
    drive_idle();
    ex_mem_read = 1'b1;
    ex_rt       = 5'd7;
    id_rt       = 5'd7;
    id_uses_rt  = 1'b1;
    #1;
    chk("lu_rt_ctrl", 32'(ctrl), 32'(C_STALL));
    id_uses_rt = 1'b0;
    #1;
    chk("rt_unused_ctrl", 32'(ctrl), 32'(C_RUN));
    drive_idle();
    ex_mem_read = 1'b1;
    ex_rt       = 5'd0;
    id_rs       = 5'd0;
    id_uses_rs  = 1'b1;
    #1;
    chk("reg0_ctrl", 32'(ctrl), 32'(C_RUN));
    drive_idle();
    ex_mdu_start = 1'b1;
    id_mdu_dep   = 1'b1;
    #1;
    chk("mdu_issue_dep_ctrl", 32'(ctrl), 32'(C_STALL));
    drive_idle();
    step();
    chk("nohaz_cycles", 32'(stall_cycles), 32'd1);
    chk("nohaz_reason", 32'(stall_reason), 32'd0);

    // MDU: issue at cycle 0, mfhi in ID from cycle 1; stalls cycles 1-4
    ex_mdu_start = 1'b1;
    #1;
    chk("mdu_issue_ctrl", 32'(ctrl), 32'(C_RUN));
    step();
    ex_mdu_start = 1'b0;
    id_mdu_dep   = 1'b1;
    chk("mdu_busy_set", 32'(mdu_busy), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("mdu_stall_ctrl_c%0d", i), 32'(ctrl), 32'(C_STALL));
      step();
      chk($sformatf("mdu_stall_reason_c%0d", i), 32'(stall_reason), 32'd2);
    end
    #1;
    chk("mdu_done_busy", 32'(mdu_busy), 32'd0);
    chk("mdu_done_ctrl", 32'(ctrl), 32'(C_RUN));
    chk("mdu_cycles", 32'(stall_cycles), 32'd5);
    step();
    chk("mdu_done_reason", 32'(stall_reason), 32'd0);
    drive_idle();

    // Branch over a load-use stall
    drive_load_use_rs(5'd9);
    ex_branch_taken = 1'b1;
    #1;
    chk("br_ctrl", 32'(ctrl), 32'(C_FLUSH));
    step();
    chk("br_reason", 32'(stall_reason), 32'd3);
    chk("br_cycles", 32'(stall_cycles), 32'd5);
    drive_idle();

    // Load-use and MDU stall together: load-use wins
    ex_mdu_start = 1'b1;
    step();
    ex_mdu_start = 1'b0;
    id_mdu_dep   = 1'b1;
    drive_load_use_rs(5'd3);
    #1;
    chk("both_ctrl", 32'(ctrl), 32'(C_STALL));
    step();
    chk("both_reason", 32'(stall_reason), 32'd1);
    chk("both_cycles", 32'(stall_cycles), 32'd6);
    ex_mem_read = 1'b0;
    step();
    chk("both_mdu_reason", 32'(stall_reason), 32'd2);
    chk("both_mdu_cycles", 32'(stall_cycles), 32'd7);
    chk("both_mdu_busy", 32'(mdu_busy), 32'd1);

    // Async reset in the middle of MDU_WAIT, between edges
    #2;
    reset = 1'b1;
    #1;
    chk("areset_busy", 32'(mdu_busy), 32'd0);
    chk("areset_ctrl", 32'(ctrl), 32'(C_RESET));
    chk("areset_reason", 32'(stall_reason), 32'd0);
    chk("areset_cycles", 32'(stall_cycles), 32'd0);
    step();
    drive_idle();
    reset = 1'b0;
    #1;
    chk("post_reset_ctrl", 32'(ctrl), 32'(C_RUN));
    chk("post_reset_busy", 32'(mdu_busy), 32'd0);
    step();
    chk("post_reset_reason", 32'(stall_reason), 32'd0);
    chk("post_reset_cycles", 32'(stall_cycles), 32'd0);

    // Saturation: 20 stall cycles on a 4-bit counter
    drive_load_use_rs(5'd12);
    for (int i = 0; i < 10; i++) step();
    chk("sat_mid_cycles", 32'(stall_cycles), 32'd10);
    for (int i = 0; i < 10; i++) step();
    chk("sat_cycles", 32'(stall_cycles), 32'd15);
    chk("sat_reason", 32'(stall_reason), 32'd1);
    drive_idle();
    step();
    chk("sat_hold_cycles", 32'(stall_cycles), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule
